// File: rtl/tv80_mcycle_seq.sv
// Machine-cycle / T-state sequencer for the TV80 core: one-hot M/T vectors,
// count latching with clamping, WAIT_n and automatic I/O wait states, clock enable.
module tv80_mcycle_seq #(
  parameter int MAX_MCYCLES = 7,
  parameter int MAX_TSTATES = 7,
  parameter int IO_WAITS    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cen,
  input  logic                   wait_n,
  input  logic [2:0]             mcycles_in,
  input  logic [2:0]             tstates_in,
  input  logic                   iorq_in,
  output logic [MAX_MCYCLES-1:0] mcycle,
  output logic [MAX_TSTATES-1:0] tstate,
  output logic                   last_tstate,
  output logic                   last_mcycle,
  output logic                   new_instr,
  output logic                   wait_active
);

  localparam logic [2:0] M_MAX   = 3'(MAX_MCYCLES);
  localparam logic [2:0] T_MAX   = 3'(MAX_TSTATES);
  localparam logic [2:0] T_MIN   = 3'd3;
  localparam logic [1:0] IO_LOAD = 2'(IO_WAITS);

  logic [MAX_MCYCLES-1:0] mcycle_q, mcycle_d;
  logic [MAX_TSTATES-1:0] tstate_q, tstate_d;
  logic [2:0]             t_cnt_q, t_cnt_d;
  logic [2:0]             m_cnt_q, m_cnt_d;
  logic [1:0]             io_cnt_q, io_cnt_d;
  logic                   new_instr_q, new_instr_d;

  logic [2:0] m_idx, t_idx;
  logic [2:0] mc_live, tc_live, m_target;
  logic       in_t1, in_t2, stall;

  // Convert the one-hot vectors to 1-based indices.
  always_comb begin
    m_idx = '0;
    t_idx = '0;
    for (int i = 0; i < MAX_MCYCLES; i++)
      if (mcycle_q[i]) m_idx = 3'(i + 1);
    for (int i = 0; i < MAX_TSTATES; i++)
      if (tstate_q[i]) t_idx = 3'(i + 1);
  end

  always_comb begin
    mc_live = (mcycles_in == 3'd0) ? 3'd1 :
              (mcycles_in > M_MAX) ? M_MAX : mcycles_in;
    tc_live = (tstates_in < T_MIN) ? T_MIN :
              (tstates_in > T_MAX) ? T_MAX : tstates_in;

    in_t1 = tstate_q[0];
    in_t2 = tstate_q[1];

    // Counts are not latched until T2 is left, so T1/T2 look at the decoder directly.
    m_target    = (in_t1 || in_t2) ? mc_live : m_cnt_q;
    last_tstate = !in_t1 && !in_t2 && (t_idx == t_cnt_q);
    // >= keeps mcycle one-hot even if the decoder shrinks the count mid-instruction.
    last_mcycle = (m_idx >= m_target);

    stall       = in_t2 && ((io_cnt_q != 2'd0) || !wait_n);
    wait_active = stall;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    mcycle_d    = mcycle_q;
    tstate_d    = tstate_q;
    t_cnt_d     = t_cnt_q;
    m_cnt_d     = m_cnt_q;
    io_cnt_d    = io_cnt_q;
    new_instr_d = 1'b0;

    if (in_t1) begin
      tstate_d = {tstate_q[MAX_TSTATES-2:0], 1'b0};
      if (!mcycle_q[0] && iorq_in) io_cnt_d = IO_LOAD;
    end else if (in_t2) begin
      if (io_cnt_q != 2'd0) io_cnt_d = io_cnt_q - 2'd1;
      if (!stall) begin
        tstate_d = {tstate_q[MAX_TSTATES-2:0], 1'b0};
        t_cnt_d  = tc_live;
        m_cnt_d  = mc_live;
      end
    end else if (last_tstate) begin
      tstate_d = MAX_TSTATES'(1);
      if (last_mcycle) begin
        mcycle_d    = MAX_MCYCLES'(1);
        new_instr_d = 1'b1;
      end else begin
        mcycle_d = {mcycle_q[MAX_MCYCLES-2:0], 1'b0};
      end
    end else begin
      tstate_d = {tstate_q[MAX_TSTATES-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_q    <= MAX_MCYCLES'(1);
      tstate_q    <= MAX_TSTATES'(1);
      t_cnt_q     <= 3'd3;
      m_cnt_q     <= 3'd3;
      io_cnt_q    <= 2'd0;
      new_instr_q <= 1'b0;
    end else if (cen) begin
      mcycle_q    <= mcycle_d;
      tstate_q    <= tstate_d;
      t_cnt_q     <= t_cnt_d;
      m_cnt_q     <= m_cnt_d;
      io_cnt_q    <= io_cnt_d;
      new_instr_q <= new_instr_d;
    end
  end

  assign mcycle    = mcycle_q;
  assign tstate    = tstate_q;
  assign new_instr = new_instr_q;

endmodule

// File: tb/tb_tv80_mcycle_seq.sv
// Self-checking bench for tv80_mcycle_seq: a default 7x7 instance plus a
// 5x5 instance for clamping, expected vectors queued per cycle and popped at negedge.
module tb_tv80_mcycle_seq;

  logic       clk = 1'b0;
  logic       reset, cen, wait_n, iorq_in;
  logic [2:0] mcycles_in, tstates_in;

  logic [6:0] mcycle7, tstate7;
  logic       lt7, lm7, ni7, wa7;
  logic [4:0] mcycle5, tstate5;
  logic       lt5, lm5, ni5, wa5;

  always #5 clk = ~clk;

  tv80_mcycle_seq #(.MAX_MCYCLES(7), .MAX_TSTATES(7), .IO_WAITS(1)) u_dut7 (
    .clk(clk), .reset(reset), .cen(cen), .wait_n(wait_n),
    .mcycles_in(mcycles_in), .tstates_in(tstates_in), .iorq_in(iorq_in),
    .mcycle(mcycle7), .tstate(tstate7), .last_tstate(lt7), .last_mcycle(lm7),
    .new_instr(ni7), .wait_active(wa7)
  );

  tv80_mcycle_seq #(.MAX_MCYCLES(5), .MAX_TSTATES(5), .IO_WAITS(1)) u_dut5 (
    .clk(clk), .reset(reset), .cen(cen), .wait_n(wait_n),
    .mcycles_in(mcycles_in), .tstates_in(tstates_in), .iorq_in(iorq_in),
    .mcycle(mcycle5), .tstate(tstate5), .last_tstate(lt5), .last_mcycle(lm5),
    .new_instr(ni5), .wait_active(wa5)
  );

  // Packed view: {mcycle, tstate, last_tstate, last_mcycle, new_instr, wait_active}
  logic [17:0] obs7, obs5;
  assign obs7 = {mcycle7, tstate7, lt7, lm7, ni7, wa7};
  assign obs5 = {2'b00, mcycle5, 2'b00, tstate5, lt5, lm5, ni5, wa5};

  int          checks   = 0;
  int          failures = 0;
  logic [17:0] sb[$];
  logic [17:0] got, exp_v;

  function automatic logic [17:0] ev(input int m, input int t,
                                     input logic lt, input logic lm,
                                     input logic ni, input logic wa);
    logic [6:0] mv, tv;
    mv = 7'd1 << m;
    tv = 7'd1 << t;
    return {mv, tv, lt, lm, ni, wa};
  endfunction

  task automatic drive(input logic c, input logic wn, input logic io,
                       input logic [2:0] mc, input logic [2:0] tc,
                       input logic [17:0] e);
    cen        = c;
    wait_n     = wn;
    iorq_in    = io;
    mcycles_in = mc;
    tstates_in = tc;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    cen        = 1'b1;
    wait_n     = 1'b1;
    iorq_in    = 1'b0;
    mcycles_in = 3'd1;
    tstates_in = 3'd4;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    cen        = 1'b1;
    wait_n     = 1'b1;
    iorq_in    = 1'b0;
    mcycles_in = 3'd3;
    tstates_in = 3'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    exp_v = sb.pop_front();
    checks++;
    if (obs7 !== exp_v) begin
      failures++;
      $display("FAIL reset7 got=%h exp=%h", obs7, exp_v);
    end
    exp_v = sb.pop_front();
    checks++;
    if (obs5 !== exp_v) begin
      failures++;
      $display("FAIL reset5 got=%h exp=%h", obs5, exp_v);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One 4-T M-cycle per instruction: new_instr every 4 clocks.
  task automatic test_single_mcycle();
    do_reset();
    for (int k = 0; k < 13; k++) begin
      int t;
      t = k % 4;
      drive(1, 1, 0, 3'd1, 3'd4, ev(0, t, t == 3, 1, (k >= 4) && (t == 0), 0));
      @(negedge clk);
      got = obs7; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL single_mcycle cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Three M-cycles of 4/3/3 T-states, two instructions back to back.
  task automatic test_multi_mcycle();
    int durs[3];
    int k;
    durs = '{4, 3, 3};
    k = 0;
    do_reset();
    for (int inst = 0; inst < 3; inst++) begin
      for (int m = 0; m < 3; m++) begin
        for (int t = 0; t < durs[m]; t++) begin
          if (inst < 2 || (m == 0 && t == 0)) begin
            drive(1, 1, 0, 3'd3, 3'(durs[m]),
                  ev(m, t, t == durs[m] - 1, m == 2, (inst > 0) && (m == 0) && (t == 0), 0));
            @(negedge clk);
            got = obs7; exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
              failures++;
              $display("FAIL multi_mcycle cycle=%0d got=%h exp=%h", k, got, exp_v);
            end
            @(posedge clk); #1;
            k++;
          end
        end
      end
    end
  endtask

  typedef struct {
    logic       wn;
    logic [2:0] tc;
    int         m;
    int         t;
    logic       lt, lm, ni, wa;
  } io_row_t;

  // M2 is an I/O cycle: one automatic wait, then wait_n low for two more T2 cycles.
  task automatic test_io_wait();
    io_row_t rows[11];
    rows = '{
      '{1'b0, 3'd4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'd4, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 3'd4, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 3'd4, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'd3, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 3'd3, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 3'd3, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 3'd3, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 3'd3, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 3'd3, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 3'd4, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0}
    };
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(1, rows[k].wn, 1, 3'd2, rows[k].tc,
            ev(rows[k].m, rows[k].t, rows[k].lt, rows[k].lm, rows[k].ni, rows[k].wa));
      @(negedge clk);
      got = obs7; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL io_wait cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // cen alternates 1,0,...: state only moves on cen=1 edges; new_instr held while cen=0.
  task automatic test_cen_gating();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      int s, t;
      s = (k + 1) / 2;
      t = s % 4;
      drive((k % 2) == 0, 1, 0, 3'd1, 3'd4, ev(0, t, t == 3, 1, (s >= 4) && (t == 0), 0));
      @(negedge clk);
      got = obs7; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL cen_gating cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // 5x5 instance: tstates 0 -> 3, mcycles 7 -> 5; then tstates 7 -> 5, mcycles 0 -> 1.
  task automatic test_clamp();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      int m, t;
      m = (k / 3) % 5;
      t = k % 3;
      drive(1, 1, 0, 3'd7, 3'd0, ev(m, t, t == 2, m == 4, k == 15, 0));
      @(negedge clk);
      got = obs5; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL clamp_low_t cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      @(posedge clk); #1;
    end
    do_reset();
    for (int k = 0; k < 11; k++) begin
      int t;
      t = k % 5;
      drive(1, 1, 0, 3'd0, 3'd7, ev(0, t, t == 4, 1, (k > 0) && (t == 0), 0));
      @(negedge clk);
      got = obs5; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL clamp_high_t cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted mid-cycle while M2 sits in an I/O wait, then a plain 2-M-cycle fetch.
  task automatic test_reset_in_wait();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      int m, t;
      m = k / 3;
      t = k % 3;
      drive(1, (m == 0), 1, 3'd2, 3'd3, ev(m, t, t == 2, m == 1, 0, k == 4));
      @(negedge clk);
      got = obs7; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL pre_reset_wait cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b1;
    sb.push_back(ev(0, 0, 0, 0, 0, 0));
    #1;
    got = obs7; exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL async_reset_in_tw got=%h exp=%h", got, exp_v);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      int m, t;
      m = (k / 3) % 2;
      t = k % 3;
      drive(1, 1, 0, 3'd2, 3'd3, ev(m, t, t == 2, m == 1, k == 6, 0));
      @(negedge clk);
      got = obs7; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL post_reset_fetch cycle=%0d got=%h exp=%h", k, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_mcycle();
    test_multi_mcycle();
    test_io_wait();
    test_cen_gating();
    test_clamp();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
